// File: rtl/mcp_pkg.sv
// Shared types and widths for the MicROM bus sequencer.
package mcp_pkg;

    localparam int MI_W     = 22;
    localparam int MA_W     = 11;
    localparam int BANK_LSB = 9;

    typedef enum logic [2:0] {
        PRE,
        C2,
        C3,
        C4,
        C1
    } phase_e;

endpackage

// File: rtl/mcp_mbus_ctl_if.sv
// Microaddress/microinstruction bus between control chip, sequencer and ROM bank.
interface mcp_mbus_ctl_if #(
    parameter int NROM = 4
);
    import mcp_pkg::*;

    logic [MA_W-1:0] mc_addr;
    logic            mc_ena;
    logic            mc_stall;
    logic            rom_c1;
    logic            rom_c2;
    logic            rom_c3;
    logic            rom_c4;
    logic [MA_W-1:0] rom_addr;
    logic [NROM-1:0] rom_sel;
    logic [MI_W-1:0] rom_data;
    logic [MI_W-1:0] mi_data;
    logic            mi_valid;
    logic            mi_miss;

    modport master (
        output mc_addr, mc_ena, mc_stall, rom_data,
        input  rom_c1, rom_c2, rom_c3, rom_c4,
        input  rom_addr, rom_sel, mi_data, mi_valid, mi_miss
    );

    modport slave (
        input  mc_addr, mc_ena, mc_stall, rom_data,
        output rom_c1, rom_c2, rom_c3, rom_c4,
        output rom_addr, rom_sel, mi_data, mi_valid, mi_miss
    );

endinterface

// File: rtl/mcp_phase_gen.sv
// Five-state phase sequencer producing non-overlapping C1..C4 strobes.
module mcp_phase_gen
    import mcp_pkg::*;
#(
    parameter int PH_LEN = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stall_i,
    output phase_e     phase_o,
    output logic       last_o,
    output logic [3:0] strb_o
);

    localparam int CW = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;

    phase_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;
    logic          guard;

    assign last = (cnt_q == CW'(PH_LEN - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PRE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
            cnt_d = '0;
            unique case (state_q)
                PRE:     state_d = C2;
                C2:      state_d = C3;
                C3:      state_d = C4;
                C4:      state_d = stall_i ? C4 : C1;
                C1:      state_d = C2;
                default: state_d = PRE;
            endcase
        end
    end

    // A stalled C4 skips its guard clock so the strobe stays solid.
    assign guard = last && !((state_q == C4) && stall_i);

    always_comb begin
        strb_o = '0;
        unique case (state_q)
            C1:      strb_o[0] = !guard;
            C2:      strb_o[1] = !guard;
            C3:      strb_o[2] = !guard;
            C4:      strb_o[3] = !guard;
            default: strb_o    = '0;
        endcase
    end

    assign phase_o = state_q;
    assign last_o  = last;

endmodule

// File: rtl/mcp_mbus_ctl.sv
// MicROM bus sequencer: address take, bank select and microinstruction capture.
module mcp_mbus_ctl
    import mcp_pkg::*;
#(
    parameter int              PH_LEN    = 3,
    parameter int              NROM      = 4,
    parameter logic [NROM-1:0] BANK_MASK = '1
) (
    input  logic          pin_clk,
    input  logic          pin_rst,
    mcp_mbus_ctl_if.slave bus
);

    phase_e          phase;
    logic            last;
    logic [3:0]      strb;
    logic            take;
    logic            cap;
    logic [1:0]      bank;

    logic [MA_W-1:0] addr_q;
    logic            fetch_q;
    logic            hit_q;
    logic [MI_W-1:0] data_q;
    logic            valid_q;
    logic            miss_q;

    mcp_phase_gen #(
        .PH_LEN (PH_LEN)
    ) u_phase (
        .clk_i   (pin_clk),
        .rst_i   (pin_rst),
        .stall_i (bus.mc_stall),
        .phase_o (phase),
        .last_o  (last),
        .strb_o  (strb)
    );

    // Leaving C1 captures the old fetch and takes the next address.
    assign take = last && ((phase == PRE) || (phase == C1));
    assign cap  = last && (phase == C1);
    assign bank = addr_q[MA_W-1:BANK_LSB];

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            addr_q  <= '0;
            fetch_q <= 1'b0;
            hit_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            valid_q <= cap;
            if (take) begin
                addr_q  <= bus.mc_addr;
                fetch_q <= bus.mc_ena;
                hit_q   <= BANK_MASK[bus.mc_addr[MA_W-1:BANK_LSB]];
            end
            if (cap) begin
                data_q <= (fetch_q && hit_q) ? bus.rom_data : '0;
                miss_q <= fetch_q && !hit_q;
            end
        end
    end

    always_comb begin
        bus.rom_sel = '0;
        if (((phase == C3) || (phase == C4)) && fetch_q && hit_q)
            bus.rom_sel = NROM'(1) << bank;
    end

    assign bus.rom_c1   = strb[0];
    assign bus.rom_c2   = strb[1];
    assign bus.rom_c3   = strb[2];
    assign bus.rom_c4   = strb[3];
    assign bus.rom_addr = addr_q;
    assign bus.mi_data  = data_q;
    assign bus.mi_valid = valid_q;
    assign bus.mi_miss  = miss_q;

endmodule

// File: tb/tb_mcp_mbus_ctl.sv
// Directed bench for the MicROM bus sequencer (PH_LEN=3).
module tb_mcp_mbus_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mcp_mbus_ctl_if #(.NROM(4)) bus ();
    mcp_mbus_ctl_if #(.NROM(4)) busm ();

    assign busm.mc_addr  = bus.mc_addr;
    assign busm.mc_ena   = bus.mc_ena;
    assign busm.mc_stall = bus.mc_stall;
    assign busm.rom_data = bus.rom_data;

    mcp_mbus_ctl #(
        .PH_LEN    (3),
        .NROM      (4),
        .BANK_MASK (4'b1111)
    ) dut (
        .pin_clk (clk),
        .pin_rst (rst),
        .bus     (bus)
    );

    mcp_mbus_ctl #(
        .PH_LEN    (3),
        .NROM      (4),
        .BANK_MASK (4'b0011)
    ) dut_m (
        .pin_clk (clk),
        .pin_rst (rst),
        .bus     (busm)
    );

    typedef struct {
        logic [10:0] addr;
        logic        ena;
        logic        stall;
        logic [21:0] data;
        logic [3:0]  str;
        logic [3:0]  sel;
        logic [10:0] ra;
        logic        vld;
        logic        miss;
        logic [21:0] mi;
    } vec_t;

    vec_t tv[27];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] strb(input int which);
        if (which == 0)
            return {bus.rom_c4, bus.rom_c3, bus.rom_c2, bus.rom_c1};
        return {busm.rom_c4, busm.rom_c3, busm.rom_c2, busm.rom_c1};
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        bus.mc_addr  = '0;
        bus.mc_ena   = 1'b0;
        bus.mc_stall = 1'b0;
        bus.rom_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.mc_addr  = 11'h7FF;
        bus.mc_ena   = 1'b1;
        bus.mc_stall = 1'b1;
        bus.rom_data = 22'h3FFFFF;
        #3;
        chk("reset_outs",
            {strb(0), bus.rom_sel, bus.rom_addr, bus.mi_valid,
             bus.mi_miss, bus.mi_data},
            64'h0);

        // Strobe pattern and two plain fetches of 0x123; junk elsewhere.
        for (int k = 0; k < 27; k++) begin
            int p, pos, ph;
            p   = k / 3;
            pos = k % 3;
            ph  = (p == 0) ? 0 : 1 + ((p - 1) % 4);
            tv[k].str   = 4'b0000;
            if (pos != 2) begin
                if (ph == 1) tv[k].str = 4'b0010;
                if (ph == 2) tv[k].str = 4'b0100;
                if (ph == 3) tv[k].str = 4'b1000;
                if (ph == 4) tv[k].str = 4'b0001;
            end
            if (pos == 2 && (ph == 0 || ph == 4)) begin
                tv[k].addr = 11'h123;
                tv[k].ena  = 1'b1;
            end else begin
                tv[k].addr = 11'h7FF;
                tv[k].ena  = 1'b0;
            end
            tv[k].stall = (ph != 3);
            tv[k].data  = (ph == 4) ? 22'h2AAAAA : (22'h3FFFFF ^ 22'(k));
            tv[k].sel   = (ph == 2 || ph == 3) ? 4'b0001 : 4'b0000;
            tv[k].ra    = (k >= 3) ? 11'h123 : 11'h000;
            tv[k].vld   = (k == 15);
            tv[k].miss  = 1'b0;
            tv[k].mi    = (k >= 15) ? 22'h2AAAAA : 22'h0;
        end

        do_reset();
        for (int k = 0; k < 27; k++) begin
            bus.mc_addr  = tv[k].addr;
            bus.mc_ena   = tv[k].ena;
            bus.mc_stall = tv[k].stall;
            bus.rom_data = tv[k].data;
            #1;
            chk($sformatf("vec%0d", k),
                {strb(0), bus.rom_sel, bus.rom_addr, bus.mi_valid,
                 bus.mi_miss, bus.mi_data},
                {tv[k].str, tv[k].sel, tv[k].ra, tv[k].vld,
                 tv[k].miss, tv[k].mi});
            @(negedge clk);
        end

        // Stall for two C4 end checks.
        do_reset();
        bus.mc_addr  = 11'h123;
        bus.mc_ena   = 1'b1;
        bus.rom_data = 22'h155555;
        for (int k = 0; k < 23; k++) begin
            bus.mc_stall = (k >= 11 && k <= 14);
            #1;
            if (k >= 9 && k <= 17)
                chk($sformatf("stall_c4_%0d", k), strb(0), (k == 17) ? 4'b0000 : 4'b1000);
            if (k >= 6 && k <= 17)
                chk($sformatf("stall_sel_%0d", k), bus.rom_sel, 4'b0001);
            if (k >= 18 && k <= 20)
                chk($sformatf("stall_c1_%0d", k), strb(0), (k == 20) ? 4'b0000 : 4'b0001);
            if (k >= 20)
                chk($sformatf("stall_vld_%0d", k), bus.mi_valid, k == 21);
            if (k == 21)
                chk("stall_data", bus.mi_data, 22'h155555);
            @(negedge clk);
        end

        // Unpopulated bank on dut_m, then a suppressed fetch on both.
        do_reset();
        bus.mc_addr  = 11'h600;
        bus.rom_data = 22'h3FFFFF;
        for (int k = 0; k < 29; k++) begin
            bus.mc_ena = (k < 14);
            #1;
            if (k >= 6 && k <= 11) begin
                chk($sformatf("hit_sel_%0d", k), bus.rom_sel, 4'b1000);
                chk($sformatf("miss_sel_%0d", k), busm.rom_sel, 4'b0000);
            end
            if (k == 14 || k == 16)
                chk($sformatf("miss_vld_%0d", k), busm.mi_valid, 1'b0);
            if (k == 15) begin
                chk("hit_cap", {bus.mi_valid, bus.mi_miss, bus.mi_data},
                    {1'b1, 1'b0, 22'h3FFFFF});
                chk("miss_cap", {busm.mi_valid, busm.mi_miss, busm.mi_data},
                    {1'b1, 1'b1, 22'h0});
            end
            if (k >= 18 && k <= 23)
                chk($sformatf("sup_sel_%0d", k), {bus.rom_sel, busm.rom_sel}, 8'h00);
            if (k == 27) begin
                chk("sup_cap", {bus.mi_valid, bus.mi_miss, bus.mi_data},
                    {1'b1, 1'b0, 22'h0});
                chk("sup_cap_m", {busm.mi_valid, busm.mi_miss, busm.mi_data},
                    {1'b1, 1'b0, 22'h0});
            end
            @(negedge clk);
        end

        // Async reset in the middle of the second fetch's C4.
        do_reset();
        bus.mc_addr  = 11'h123;
        bus.mc_ena   = 1'b1;
        bus.rom_data = 22'h2AAAAA;
        for (int k = 0; k < 22; k++) @(negedge clk);
        #1;
        chk("pre_rst", {strb(0), bus.rom_sel, bus.mi_data},
            {4'b1000, 4'b0001, 22'h2AAAAA});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst",
            {strb(0), bus.rom_sel, bus.rom_addr, bus.mi_valid,
             bus.mi_miss, bus.mi_data},
            64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk($sformatf("abort_vld_%0d", k), bus.mi_valid, 1'b0);
            if (k < 3)
                chk($sformatf("abort_pre_%0d", k), strb(0), 4'b0000);
            if (k == 3)
                chk("abort_c2", strb(0), 4'b0010);
            @(negedge clk);
        end

        // Back-to-back fetches across all four banks.
        do_reset();
        bus.mc_ena = 1'b1;
        for (int k = 0; k < 52; k++) begin
            logic [1:0] b;
            b = 2'(k / 12);
            bus.mc_addr  = (k % 12 == 2) ? {b, 9'h001} : 11'h7FF;
            bus.rom_data = (k >= 12) ? 22'(22'h0ABC0 + k / 12 - 1) : 22'h0;
            #1;
            if (k % 12 == 6)
                chk($sformatf("b2b_sel_%0d", k), bus.rom_sel, 4'(4'b0001 << (k / 12)));
            if (k >= 14 && k % 12 == 2)
                chk($sformatf("b2b_idle_%0d", k), bus.mi_valid, 1'b0);
            if (k >= 15 && k % 12 == 3)
                chk($sformatf("b2b_cap_%0d", k), {bus.mi_valid, bus.mi_data},
                    {1'b1, 22'(22'h0ABC0 + (k - 15) / 12)});
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mcp_mbus_ctl.md
Name: mcp_mbus_ctl

Overview:
Synchronous microinstruction-bus sequencer for a bank of MicROM chips (1631-style, 2K x 22).
- Derives the four non-overlapping phase strobes (C1..C4) from one master clock.
- Latches the next microaddress from the control chip and selects the addressed ROM bank.
- Captures the returned 22-bit microinstruction.
- Replaces the open-drain, precharged bus with separate address and data paths for synthesis and simulation.

Parameters:
PH_LEN, 3, master clocks per phase (legal >= 2).
NROM, 4, number of ROM bank selects; bank = mc_addr[10:9].
BANK_MASK, 4'b1111, populated-bank mask; bit n = bank n present.

Ports:
pin_clk  in  1  master clock.
pin_rst  in  1  reset, asynchronous, active-high.
mc_addr  in  11  next microaddress from the control chip.
mc_ena  in  1  fetch enable; low = suppressed fetch (bus-16 disable equivalent).
mc_stall  in  1  extend precharge (C4).
rom_c1..rom_c4  out  1 each  phase strobes to the ROM banks.
rom_addr  out  11  latched microaddress.
rom_sel  out  NROM  one-hot bank select.
rom_data  in  22  selected bank output, already OR-ed across banks.
mi_data  out  22  captured microinstruction.
mi_valid  out  1  one-clock pulse: new mi_data available.
mi_miss  out  1  qualifies mi_valid: addressed bank not populated.

Behaviour:
Phase sequencer
- States: PRE, C2, C3, C4, C1.
- Each state lasts PH_LEN clocks, counted by a phase counter of width $clog2(PH_LEN).
- Order after reset: PRE -> C2 -> C3 -> C4 -> C1 -> C2 ...
- Strobe rom_cN is high on clocks 0..PH_LEN-2 of phase N and low on the last clock (non-overlap guard).
- All strobes are low in PRE.

Reset (async)
- Forces PRE with counter 0.
- rom_c1..c4=0, rom_addr=0, rom_sel=0, mi_data=0, mi_valid=0, mi_miss=0.
- Any fetch in flight is discarded: no mi_valid is produced for it.

Address take
- Occurs on the edge entering C2, from either PRE or C1.
- rom_addr <= mc_addr.
- Fetch flag <= mc_ena.
- Bank index = mc_addr[10:9].
- Hit flag <= BANK_MASK[index].

Bank select
- rom_sel = one-hot(bank) only during C3 and C4 of a fetch with flag=1 and hit=1; otherwise 0.

Stall
- mc_stall is sampled on the last clock of C4.
- If high: C4 repeats for another PH_LEN clocks, rom_c4 stays high continuously with no guard gap, and rom_sel is held.
- Re-evaluated at the end of each repeat.

Data capture
- Occurs on the edge leaving C1, which is the same edge as the next address take.
- Enabled fetch, hit: mi_data <= rom_data, mi_miss <= 0.
- Enabled fetch, miss: mi_data <= 0, mi_miss <= 1.
- Suppressed fetch (mc_ena=0): mi_data <= 0, mi_miss <= 0.
- mi_valid is high for exactly the next clock, then 0.
- Leaving PRE never produces mi_valid.

Latency
- Address-take edge to mi_valid high = 4*PH_LEN clocks with no stall.
- Each stall repeat adds PH_LEN clocks.

Other rules
- mc_addr and mc_ena are ignored outside the address-take edge.
- rom_data is ignored outside the capture edge.

Decomposition:
Shared package (mcp_pkg):
- Phase-state enum {PRE, C2, C3, C4, C1}.
- MI_W=22, MA_W=11, BANK_LSB=9.

Sub-module mcp_phase_gen:
- Contains the state register, phase counter, stall handling and strobe/guard decode.
- Exports the current phase, a last-clock-of-phase flag and the four strobes.
- mcp_mbus_ctl adds the address, bank and capture logic.

Test Plan:
1. Strobe pattern (PH_LEN=3): release reset, mc_stall=0 -> PRE for 3 clocks with strobes low, then rom_c2 high 2 clocks / low 1, then c3, c4, c1 the same way. Period 12 clocks; no two strobes are ever high together.
2. Basic fetch: mc_addr=11'h123, mc_ena=1, rom_data=22'h2AAAAA during C1 -> rom_sel=4'b0001 in C3/C4; 12 clocks after the take edge mi_valid=1 for 1 clock, mi_data=22'h2AAAAA, mi_miss=0.
3. Stall: mc_stall=1 during two consecutive C4 end checks -> C4 lasts 9 clocks with rom_c4 continuously high and rom_sel held; mi_valid arrives 18 clocks after the take edge.
4. Miss and suppress:
   - BANK_MASK=4'b0011, mc_addr=11'h600 -> rom_sel=0, mi_valid with mi_data=0, mi_miss=1.
   - mc_ena=0 -> mi_valid with mi_data=0, mi_miss=0, rom_sel=0.
5. Reset mid-fetch: assert pin_rst during C4 -> all outputs 0 immediately (async); after release, PRE then C2, and no mi_valid for the aborted fetch.
6. Back-to-back: addresses 0x001, 0x201, 0x401, 0x601 on successive cycles -> rom_sel 0001, 0010, 0100, 1000 in order, and mi_valid pulses every 12 clocks with the matching data.
